// File: rtl/wfg_subcore_monitor.sv
// Subcore timebase checker: subcycle spacing and subcycles-per-sync vs programmed N/M.
// All outputs registered (1-cycle latency); observe-only, never backpressures the subcore.
module wfg_subcore_monitor #(
  parameter int LOCK_SYNCS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        clr_err_i,
  input  logic [15:0] wfg_subcycle_count_i,
  input  logic [7:0]  wfg_sync_count_i,
  input  logic        wfg_subcore_start_i,
  input  logic        wfg_subcore_subcycle_i,
  input  logic        wfg_subcore_sync_i,
  output logic        locked_o,
  output logic        err_period_o,
  output logic        err_sync_o,
  output logic [17:0] meas_period_o,
  output logic [8:0]  meas_subcycles_o
);

  typedef enum logic [1:0] {IDLE, ARMED, ACQUIRE, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_SYNCS);

  state_t      state;
  logic [17:0] cyc;
  logic [8:0]  sub;
  logic [3:0]  good;
  logic        ref_vld;
  logic        int_perr;

  logic [17:0] per_exp;
  logic [17:0] per_tmo;
  logic [8:0]  sub_exp;
  logic        sc;
  logic        sy;
  logic        perr;
  logic        serr;
  logic        sync_good;

  assign sc      = wfg_subcore_subcycle_i;
  assign sy      = wfg_subcore_sync_i;
  assign per_exp = {1'b0, wfg_subcycle_count_i, 1'b0} + 18'd2;
  assign per_tmo = per_exp + 18'd1;
  assign sub_exp = {1'b0, wfg_sync_count_i} + 9'd1;

  // Pulse at the wrong spacing, or no pulse one cycle past the expected spacing.
  assign perr      = ref_vld & (sc ? (cyc != per_exp) : (cyc == per_tmo));
  assign serr      = sy & ((state == ACQUIRE) | (state == LOCKED)) & (sub != sub_exp);
  assign sync_good = sy & ~serr & ~perr & ~int_perr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cyc              <= '0;
      sub              <= '0;
      good             <= '0;
      ref_vld          <= 1'b0;
      int_perr         <= 1'b0;
      locked_o         <= 1'b0;
      err_period_o     <= 1'b0;
      err_sync_o       <= 1'b0;
      meas_period_o    <= '0;
      meas_subcycles_o <= '0;
    end else begin
      // A new error outranks a simultaneous clear.
      err_period_o <= (err_period_o & ~clr_err_i) | perr;
      err_sync_o   <= (err_sync_o & ~clr_err_i) | serr;

      if (!en_i || state == IDLE) begin
        cyc      <= '0;
        sub      <= '0;
        good     <= '0;
        ref_vld  <= 1'b0;
        int_perr <= 1'b0;
        locked_o <= 1'b0;
        state    <= (en_i && wfg_subcore_start_i) ? ARMED : IDLE;
      end else begin
        if (sc) begin
          cyc           <= 18'd1;
          meas_period_o <= cyc;
          ref_vld       <= 1'b1;
        end else if (cyc != 18'h3FFFF) begin
          cyc <= cyc + 18'd1;
        end

        // A coincident subcycle belongs to the new interval.
        if (sy) begin
          meas_subcycles_o <= sub;
          sub              <= sc ? 9'd1 : 9'd0;
          int_perr         <= perr;
        end else begin
          if (sc && sub != 9'h1FF) sub <= sub + 9'd1;
          if (perr) int_perr <= 1'b1;
        end

        if (wfg_subcore_start_i) begin
          state    <= ARMED;
          ref_vld  <= 1'b0;
          good     <= '0;
          locked_o <= 1'b0;
        end else begin
          case (state)
            ARMED: begin
              if (sy) begin
                state <= ACQUIRE;
                good  <= '0;
              end
            end
            ACQUIRE: begin
              if (perr || serr) begin
                good <= '0;
              end else if (sync_good) begin
                good <= good + 4'd1;
                if (good + 4'd1 >= LOCK_N) begin
                  state    <= LOCKED;
                  locked_o <= 1'b1;
                end
              end
            end
            LOCKED: begin
              if (perr || serr) begin
                state    <= ACQUIRE;
                good     <= '0;
                locked_o <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_wfg_subcore_monitor.sv
// Directed bench for wfg_subcore_monitor: event table for the N=3/M=2 stream plus corner sequences.
module tb_wfg_subcore_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_i = 1'b0;
  logic        clr_err_i = 1'b0;
  logic [15:0] n_cfg = 16'd3;
  logic [7:0]  m_cfg = 8'd2;
  logic        start_i = 1'b0;
  logic        sc_i = 1'b0;
  logic        sy_i = 1'b0;
  logic        locked_o;
  logic        err_period_o;
  logic        err_sync_o;
  logic [17:0] meas_period_o;
  logic [8:0]  meas_subcycles_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wfg_subcore_monitor #(.LOCK_SYNCS(2)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .en_i                   (en_i),
    .clr_err_i              (clr_err_i),
    .wfg_subcycle_count_i   (n_cfg),
    .wfg_sync_count_i       (m_cfg),
    .wfg_subcore_start_i    (start_i),
    .wfg_subcore_subcycle_i (sc_i),
    .wfg_subcore_sync_i     (sy_i),
    .locked_o               (locked_o),
    .err_period_o           (err_period_o),
    .err_sync_o             (err_sync_o),
    .meas_period_o          (meas_period_o),
    .meas_subcycles_o       (meas_subcycles_o)
  );

  // gap quiet cycles, then one cycle with the given pulses, then expected outputs.
  typedef struct {
    int gap;
    int start, sc, sy, clr, m;
    int lck, ep, es, per, subs;
  } vec_t;

  vec_t vecs[24];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int lck, input int ep, input int es,
                         input int per, input int subs);
    chk({tag, " locked"}, int'(locked_o), lck);
    chk({tag, " err_period"}, int'(err_period_o), ep);
    chk({tag, " err_sync"}, int'(err_sync_o), es);
    chk({tag, " meas_period"}, int'(meas_period_o), per);
    chk({tag, " meas_subcycles"}, int'(meas_subcycles_o), subs);
  endtask

  // Ideal stream, P=8: sync on every third subcycle, starting with the first.
  task automatic ideal(input int n);
    for (int i = 0; i < n; i++) begin
      quiet(7);
      sc_i = 1'b1;
      sy_i = (i % 3 == 0);
      tick();
      sc_i = 1'b0;
      sy_i = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    //            gap st sc sy cl m  lck ep es per subs
    vecs[0]  = '{2, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0};
    vecs[1]  = '{3, 0, 1, 1, 0, 2, 0, 0, 0, 3, 0};
    vecs[2]  = '{7, 0, 1, 0, 0, 2, 0, 0, 0, 8, 0};
    vecs[3]  = '{7, 0, 1, 0, 0, 2, 0, 0, 0, 8, 0};
    vecs[4]  = '{7, 0, 1, 1, 0, 2, 0, 0, 0, 8, 3};
    vecs[5]  = '{7, 0, 1, 0, 0, 2, 0, 0, 0, 8, 3};
    vecs[6]  = '{7, 0, 1, 0, 0, 2, 0, 0, 0, 8, 3};
    vecs[7]  = '{7, 0, 1, 1, 0, 2, 1, 0, 0, 8, 3};
    vecs[8]  = '{8, 0, 1, 0, 0, 2, 0, 1, 0, 9, 3};
    vecs[9]  = '{7, 0, 1, 0, 0, 2, 0, 1, 0, 8, 3};
    vecs[10] = '{7, 0, 1, 1, 0, 2, 0, 1, 0, 8, 3};
    vecs[11] = '{7, 0, 1, 0, 0, 2, 0, 1, 0, 8, 3};
    vecs[12] = '{7, 0, 1, 0, 0, 2, 0, 1, 0, 8, 3};
    vecs[13] = '{7, 0, 1, 1, 0, 2, 0, 1, 0, 8, 3};
    vecs[14] = '{7, 0, 1, 0, 0, 2, 0, 1, 0, 8, 3};
    vecs[15] = '{7, 0, 1, 0, 0, 2, 0, 1, 0, 8, 3};
    vecs[16] = '{7, 0, 1, 1, 0, 2, 1, 1, 0, 8, 3};
    vecs[17] = '{7, 0, 1, 0, 1, 2, 1, 0, 0, 8, 3};
    vecs[18] = '{7, 0, 1, 0, 0, 3, 1, 0, 0, 8, 3};
    vecs[19] = '{7, 0, 1, 1, 0, 3, 0, 0, 1, 8, 3};
    vecs[20] = '{7, 0, 1, 0, 0, 2, 0, 0, 1, 8, 3};
    vecs[21] = '{7, 0, 1, 0, 0, 2, 0, 0, 1, 8, 3};
    vecs[22] = '{7, 0, 1, 1, 1, 3, 0, 0, 1, 8, 3};
    vecs[23] = '{7, 0, 1, 0, 1, 2, 0, 0, 0, 8, 3};

    quiet(2);
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    en_i = 1'b1;

    // Lock, delayed subcycle and relock, clear, M mismatch, clear vs. new error.
    for (int v = 0; v < 24; v++) begin
      m_cfg = 8'(vecs[v].m);
      quiet(vecs[v].gap);
      start_i   = (vecs[v].start != 0);
      sc_i      = (vecs[v].sc != 0);
      sy_i      = (vecs[v].sy != 0);
      clr_err_i = (vecs[v].clr != 0);
      tick();
      start_i   = 1'b0;
      sc_i      = 1'b0;
      sy_i      = 1'b0;
      clr_err_i = 1'b0;
      chk_all($sformatf("vec%0d", v), vecs[v].lck, vecs[v].ep, vecs[v].es,
              vecs[v].per, vecs[v].subs);
    end

    // Pulses stop while locked: timeout flagged on the 9th quiet cycle.
    m_cfg = 8'd2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_start();
    ideal(7);
    chk("stop pre locked", int'(locked_o), 1);
    chk("stop pre err_period", int'(err_period_o), 0);
    quiet(8);
    chk("stop 8 err_period", int'(err_period_o), 0);
    chk("stop 8 locked", int'(locked_o), 1);
    tick();
    chk("stop 9 err_period", int'(err_period_o), 1);
    chk("stop 9 locked", int'(locked_o), 0);

    // Restart and relock keep the sticky flag; en_i low drops lock only.
    pulse_start();
    ideal(7);
    chk("relock locked", int'(locked_o), 1);
    chk("relock err_period sticky", int'(err_period_o), 1);
    en_i = 1'b0;
    tick();
    chk("en low locked", int'(locked_o), 0);
    chk("en low err_period", int'(err_period_o), 1);
    chk("en low meas_period", int'(meas_period_o), 8);
    quiet(3);
    chk("idle locked", int'(locked_o), 0);

    // Asynchronous reset mid-interval clears everything immediately.
    en_i = 1'b1;
    pulse_start();
    ideal(7);
    chk("pre rst locked", int'(locked_o), 1);
    quiet(3);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async rst", 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post rst locked", int'(locked_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wfg_subcore_monitor.md
# wfg_subcore_monitor

Receive-side checker for the subcore timing pulses (start, subcycle, sync). It measures subcycle pulse spacing and subcycles per sync interval, compares them against the programmed thresholds, and reports lock and sticky error status. It sits beside the subcore on the same clock, for example in front of a core that consumes the timebase, and is readable via status outputs.

## Interface
- LOCK_SYNCS, default 2: number of consecutive good sync intervals required to assert lock (1..15).
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- en_i  input  1  enable; low forces IDLE
- clr_err_i  input  1  clears the sticky error flags
- wfg_subcycle_count_i  input  16  programmed subcycle threshold N
- wfg_sync_count_i  input  8  programmed sync threshold M
- wfg_subcore_start_i  input  1  start pulse (1 cycle)
- wfg_subcore_subcycle_i  input  1  subcycle pulse (1 cycle)
- wfg_subcore_sync_i  input  1  sync pulse (1 cycle)
- locked_o  output  1  timebase matches configuration
- err_period_o  output  1  sticky: bad or missing subcycle spacing
- err_sync_o  output  1  sticky: bad subcycle count per sync interval
- meas_period_o  output  18  last measured subcycle spacing, in clk cycles
- meas_subcycles_o  output  9  last measured subcycles per sync interval

## Operation
- Protocol: expected spacing P = 2*(N+1), computed as {N,1'b0}+2 in 18 bits (max 131072). Expected subcycles per sync S = M+1, in 9 bits.
- A sync pulse may coincide with a subcycle pulse. A coincident subcycle counts as the first subcycle of the new interval.
- Cycle counter cyc (18 bits):
  - loads 1 on a subcycle pulse, otherwise increments;
  - saturates at 2^18-1.
- On a subcycle pulse, cyc is captured into meas_period_o. The pulse is checked against P if the period reference is valid. The reference becomes valid at the first subcycle pulse after entering ARMED.
- Timeout: reference valid and cyc == P+1 with no pulse gives a period error immediately.
- Subcycle counter sub (9 bits, saturating at 511):
  - on a sync pulse, sub is captured into meas_subcycles_o, then reloads to 1 if a subcycle pulse is coincident, else 0;
  - on a subcycle pulse alone, sub increments.
- FSM:
  - IDLE: counters cleared, locked_o=0. Goes to ARMED when en_i & start_i.
  - ARMED: waits for the first sync pulse, then goes to ACQUIRE with good=0. That interval is not checked.
  - ACQUIRE: each sync pulse where meas == S and no period error occurred in the interval increments good. When good reaches LOCK_SYNCS, go to LOCKED. Any error sets good=0 and stays in ACQUIRE.
  - LOCKED: any error goes to ACQUIRE with good=0.
  - Any state goes to IDLE when en_i=0.
  - start_i in ARMED, ACQUIRE or LOCKED restarts to ARMED and invalidates the period reference.
- Sticky errors are set in ACQUIRE and LOCKED and in ARMED for period errors. They persist through en_i=0 and restart. They clear only on clr_err_i or rst.
- Config changes are not tracked; a mismatch simply produces an error.

## Timing
- Reset: all outputs 0, FSM IDLE, cyc/sub/good 0.
- Every output is registered, with 1-cycle latency:
  - meas_* updates on the cycle after the pulse;
  - an error flag sets, and locked_o clears, on the cycle after the offending pulse or timeout;
  - locked_o sets on the cycle after the LOCK_SYNCS-th good sync pulse.
- clr_err_i in the same cycle as a new error: the error wins (flag stays 1).
- Sync and subcycle coincident: both are evaluated in the same cycle, with sub reloaded to 1.
- Both a period error and a sync error in the same cycle: both flags set, and the FSM does a single transition to ACQUIRE.
- rst mid-operation: immediate return to reset state; no partial measurement survives.

## Test plan
- N=3, M=2, LOCK_SYNCS=2, ideal pulse stream after start -> meas_period_o=8, meas_subcycles_o=3, locked_o=1 the cycle after the 3rd sync pulse (ARMED sync + 2 good), no errors.
- Locked stream, one subcycle pulse delayed by 1 cycle -> meas_period_o=9, err_period_o=1, locked_o=0 next cycle, relock after 2 further good sync intervals.
- Locked, subcycle pulses stop -> err_period_o rises 9 cycles after the last pulse.
- Locked, M changed to 3 with the generator still at 2 -> err_sync_o=1 at the next sync, meas_subcycles_o=3, locked_o=0.
- clr_err_i asserted alone -> flags clear next cycle; clr_err_i with a simultaneous error -> flag stays 1.
- en_i low mid-lock -> IDLE, locked_o=0, sticky flags retained. rst asserted mid-interval -> all outputs 0 at once.
